// File: rtl/ula_sequenciador.sv
// ula_sequenciador: sequencer in front of a multi-cycle 4-bit ULA datapath.
// It latches one operation, lets the datapath settle for LAT cycles, captures
// the result and holds it until the consumer takes it. Illegal opcodes are
// answered directly with an error result and never reach the datapath.
// Optional feature macro: ULA_SEQ_ACC_EN adds the req_acc input and an
// accumulator that can replace operand A and carry-in with the last result.
module ula_sequenciador #(
    parameter int LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_a,
    input  logic [3:0] req_b,
    input  logic       req_cin,
    input  logic [2:0] req_op,
`ifdef ULA_SEQ_ACC_EN
    input  logic       req_acc,
`endif
    output logic [3:0] ula_a,
    output logic [3:0] ula_b,
    output logic       ula_cin,
    output logic [2:0] ula_sel,
    input  logic [7:0] ula_res,
    input  logic       ula_cout,
    input  logic       ula_err,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_cout,
    output logic       res_err,
    output logic       busy,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAT_C      = 4'(LAT);
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] ula_a_q, ula_a_d;
    logic [3:0] ula_b_q, ula_b_d;
    logic       ula_cin_q, ula_cin_d;
    logic [2:0] ula_sel_q, ula_sel_d;
    logic [7:0] res_data_q, res_data_d;
    logic       res_cout_q, res_cout_d;
    logic       res_err_q, res_err_d;
    logic       res_valid_q, res_valid_d;
    logic       req_ready_q, req_ready_d;
    logic       busy_q, busy_d;
    logic [7:0] op_count_q, op_count_d;
`ifdef ULA_SEQ_ACC_EN
    logic [3:0] acc_q, acc_d;
    logic       acc_cout_q, acc_cout_d;
`endif

    // Next-state logic: sequencing, operand latch, result capture, counters.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ula_a_d    = ula_a_q;
        ula_b_d    = ula_b_q;
        ula_cin_d  = ula_cin_q;
        ula_sel_d  = ula_sel_q;
        res_data_d = res_data_q;
        res_cout_d = res_cout_q;
        res_err_d  = res_err_q;
        op_count_d = op_count_q;
`ifdef ULA_SEQ_ACC_EN
        acc_d      = acc_q;
        acc_cout_d = acc_cout_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_op == OP_ILLEGAL) begin
                        // Answer immediately; the datapath keeps its old operands.
                        state_d    = DONE;
                        res_data_d = 8'h00;
                        res_cout_d = 1'b0;
                        res_err_d  = 1'b1;
                    end else begin
                        state_d   = ISSUE;
                        ula_b_d   = req_b;
                        ula_sel_d = req_op;
`ifdef ULA_SEQ_ACC_EN
                        ula_a_d   = req_acc ? acc_q : req_a;
                        ula_cin_d = req_acc ? acc_cout_q : req_cin;
`else
                        ula_a_d   = req_a;
                        ula_cin_d = req_cin;
`endif
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                cnt_d   = LAT_C;
                state_d = WAIT;
            end
            WAIT: begin
                // A count of one marks the last settle cycle; <= also catches a stray zero.
                if (cnt_q <= 4'd1) begin
                    cnt_d      = 4'd0;
                    res_data_d = ula_res;
                    res_cout_d = ula_cout;
                    res_err_d  = ula_err;
                    state_d    = DONE;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = WAIT;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d    = IDLE;
                    op_count_d = op_count_q + 8'd1;
`ifdef ULA_SEQ_ACC_EN
                    acc_d      = res_data_q[3:0];
                    acc_cout_d = res_cout_q;
`endif
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Status outputs are registered copies decoded from the next state.
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        res_valid_d = (state_d == DONE);
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            ula_a_q     <= 4'd0;
            ula_b_q     <= 4'd0;
            ula_cin_q   <= 1'b0;
            ula_sel_q   <= 3'b000;
            res_data_q  <= 8'h00;
            res_cout_q  <= 1'b0;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            op_count_q  <= 8'd0;
`ifdef ULA_SEQ_ACC_EN
            acc_q       <= 4'd0;
            acc_cout_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ula_a_q     <= ula_a_d;
            ula_b_q     <= ula_b_d;
            ula_cin_q   <= ula_cin_d;
            ula_sel_q   <= ula_sel_d;
            res_data_q  <= res_data_d;
            res_cout_q  <= res_cout_d;
            res_err_q   <= res_err_d;
            res_valid_q <= res_valid_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            op_count_q  <= op_count_d;
`ifdef ULA_SEQ_ACC_EN
            acc_q       <= acc_d;
            acc_cout_q  <= acc_cout_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign ula_a     = ula_a_q;
    assign ula_b     = ula_b_q;
    assign ula_cin   = ula_cin_q;
    assign ula_sel   = ula_sel_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_cout  = res_cout_q;
    assign res_err   = res_err_q;
    assign busy      = busy_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_ula_sequenciador.sv
// tb_ula_sequenciador: two sequencers (LAT=1 and LAT=4) driven by directed and
// random operations; expected results, latencies and counters come from a
// transaction-level reference model plus a behavioural ULA datapath model.
module tb_ula_sequenciador;

    localparam int LAT0 = 1;
    localparam int LAT1 = 4;

    logic       clk;
    logic       rst       [2];
    logic       req_valid [2];
    logic       req_ready [2];
    logic [3:0] req_a     [2];
    logic [3:0] req_b     [2];
    logic       req_cin   [2];
    logic [2:0] req_op    [2];
`ifdef ULA_SEQ_ACC_EN
    logic       req_acc   [2];
`endif
    logic [3:0] ula_a     [2];
    logic [3:0] ula_b     [2];
    logic       ula_cin   [2];
    logic [2:0] ula_sel   [2];
    logic [7:0] ula_res   [2];
    logic       ula_cout  [2];
    logic       ula_err   [2];
    logic       res_valid [2];
    logic       res_ready [2];
    logic [7:0] res_data  [2];
    logic       res_cout  [2];
    logic       res_err   [2];
    logic       busy      [2];
    logic [7:0] op_count  [2];

    int n_cmp;
    int n_bad;

    // Reference model state per sequencer.
    logic [3:0] m_a    [2];
    logic [3:0] m_b    [2];
    logic       m_cin  [2];
    logic [2:0] m_sel  [2];
    int         m_cnt  [2];
    logic [3:0] m_acc  [2];
    logic       m_accc [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ula_sequenciador #(.LAT(g == 0 ? LAT0 : LAT1)) u_dut (
            .clk      (clk),
            .rst      (rst[g]),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_a    (req_a[g]),
            .req_b    (req_b[g]),
            .req_cin  (req_cin[g]),
            .req_op   (req_op[g]),
`ifdef ULA_SEQ_ACC_EN
            .req_acc  (req_acc[g]),
`endif
            .ula_a    (ula_a[g]),
            .ula_b    (ula_b[g]),
            .ula_cin  (ula_cin[g]),
            .ula_sel  (ula_sel[g]),
            .ula_res  (ula_res[g]),
            .ula_cout (ula_cout[g]),
            .ula_err  (ula_err[g]),
            .res_valid(res_valid[g]),
            .res_ready(res_ready[g]),
            .res_data (res_data[g]),
            .res_cout (res_cout[g]),
            .res_err  (res_err[g]),
            .busy     (busy[g]),
            .op_count (op_count[g])
        );
    end

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ULA: returns {err, cout, res}.
    function automatic logic [9:0] ula_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic cin, input logic [2:0] sel);
        int   ai;
        int   bi;
        int   r;
        logic err;
        ai  = int'(a);
        bi  = int'(b);
        r   = 0;
        err = 1'b0;
        case (sel)
            3'b000: r = ai + bi + int'(cin);
            3'b001: begin
                if (ai < bi + int'(cin)) err = 1'b1;
                else r = ai - bi - int'(cin);
            end
            3'b010: r = int'(a & b);
            3'b011: r = int'(a | b);
            3'b100: r = ai * bi;
            3'b101: r = int'(a ^ b);
            3'b110: begin
                if (bi == 0) err = 1'b1;
                else r = ai / bi;
            end
            default: r = 0;
        endcase
        return {err, (sel == 3'b000) && (r > 15), r[7:0]};
    endfunction

    // Datapath model attached to both sequencers.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            {ula_err[i], ula_cout[i], ula_res[i]} = ula_model(ula_a[i], ula_b[i], ula_cin[i], ula_sel[i]);
        end
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_ula(input int d, input string where);
        check($sformatf("d%0d %s ula_a", d, where), 32'(ula_a[d]), 32'(m_a[d]));
        check($sformatf("d%0d %s ula_b", d, where), 32'(ula_b[d]), 32'(m_b[d]));
        check($sformatf("d%0d %s ula_cin", d, where), 32'(ula_cin[d]), 32'(m_cin[d]));
        check($sformatf("d%0d %s ula_sel", d, where), 32'(ula_sel[d]), 32'(m_sel[d]));
    endtask

    task automatic model_reset(input int d);
        m_a[d] = 4'd0; m_b[d] = 4'd0; m_cin[d] = 1'b0; m_sel[d] = 3'b000;
        m_cnt[d] = 0; m_acc[d] = 4'd0; m_accc[d] = 1'b0;
    endtask

    task automatic chk_idle_after_reset(input int d, input string where);
        check($sformatf("d%0d %s req_ready", d, where), 32'(req_ready[d]), 32'd1);
        check($sformatf("d%0d %s busy", d, where), 32'(busy[d]), 32'd0);
        check($sformatf("d%0d %s res_valid", d, where), 32'(res_valid[d]), 32'd0);
        check($sformatf("d%0d %s res_data", d, where), 32'(res_data[d]), 32'd0);
        check($sformatf("d%0d %s res_cout", d, where), 32'(res_cout[d]), 32'd0);
        check($sformatf("d%0d %s res_err", d, where), 32'(res_err[d]), 32'd0);
        check($sformatf("d%0d %s op_count", d, where), 32'(op_count[d]), 32'd0);
        chk_ula(d, where);
    endtask

    // One complete operation: accept, latency, optional hold with res_ready low, handshake.
    task automatic do_op(input int d, input logic [3:0] a, input logic [3:0] b, input logic cin,
                         input logic [2:0] op, input logic acc, input int hold);
        logic [9:0] r;
        logic [7:0] e_data;
        logic       e_cout;
        logic       e_err;
        logic       use_acc;
        int         lat;
        check($sformatf("d%0d ready_before_accept", d), 32'(req_ready[d]), 32'd1);
`ifdef ULA_SEQ_ACC_EN
        use_acc    = acc;
        req_acc[d] = acc;
`else
        use_acc    = 1'b0;
`endif
        req_valid[d] = 1'b1;
        req_a[d]     = a;
        req_b[d]     = b;
        req_cin[d]   = cin;
        req_op[d]    = op;
        res_ready[d] = 1'b0;
        if (op == 3'b111) begin
            e_data = 8'h00; e_cout = 1'b0; e_err = 1'b1;
            lat    = 1;
        end else begin
            m_a[d]   = use_acc ? m_acc[d] : a;
            m_cin[d] = use_acc ? m_accc[d] : cin;
            m_b[d]   = b;
            m_sel[d] = op;
            r        = ula_model(m_a[d], m_b[d], m_cin[d], m_sel[d]);
            e_err    = r[9];
            e_cout   = r[8];
            e_data   = r[7:0];
            lat      = lat_of(d) + 2;
        end
        for (int n = 1; n <= lat; n++) begin
            @(negedge clk);
            check($sformatf("d%0d op%0d res_valid@%0d", d, op, n), 32'(res_valid[d]), 32'(n == lat));
            check($sformatf("d%0d req_ready_busy@%0d", d, n), 32'(req_ready[d]), 32'd0);
            check($sformatf("d%0d busy@%0d", d, n), 32'(busy[d]), 32'd1);
            chk_ula(d, "pending");
            // Competing request traffic that must be ignored.
            req_a[d]   = 4'($urandom);
            req_b[d]   = 4'($urandom);
            req_cin[d] = 1'($urandom);
            req_op[d]  = 3'($urandom);
`ifdef ULA_SEQ_ACC_EN
            req_acc[d] = 1'($urandom);
`endif
            if (n < lat) res_ready[d] = 1'($urandom);
            else res_ready[d] = (hold == 0);
        end
        check($sformatf("d%0d op%0d res_data", d, op), 32'(res_data[d]), 32'(e_data));
        check($sformatf("d%0d op%0d res_cout", d, op), 32'(res_cout[d]), 32'(e_cout));
        check($sformatf("d%0d op%0d res_err", d, op), 32'(res_err[d]), 32'(e_err));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check($sformatf("d%0d hold res_valid", d), 32'(res_valid[d]), 32'd1);
            check($sformatf("d%0d hold req_ready", d), 32'(req_ready[d]), 32'd0);
            check($sformatf("d%0d hold res_data", d), 32'(res_data[d]), 32'(e_data));
            check($sformatf("d%0d hold res_err", d), 32'(res_err[d]), 32'(e_err));
            chk_ula(d, "hold");
            req_a[d]     = 4'($urandom);
            req_op[d]    = 3'($urandom);
            res_ready[d] = (h == hold - 1);
        end
        req_valid[d] = 1'b0;
        @(negedge clk);
        m_cnt[d]  = (m_cnt[d] + 1) % 256;
        m_acc[d]  = e_data[3:0];
        m_accc[d] = e_cout;
        res_ready[d] = 1'b0;
        check($sformatf("d%0d op_count", d), 32'(op_count[d]), 32'(m_cnt[d]));
        check($sformatf("d%0d post res_valid", d), 32'(res_valid[d]), 32'd0);
        check($sformatf("d%0d post req_ready", d), 32'(req_ready[d]), 32'd1);
        check($sformatf("d%0d post busy", d), 32'(busy[d]), 32'd0);
        chk_ula(d, "post");
    endtask

    // Accept a legal operation, then reset k cycles later; it must vanish.
    task automatic abort_op(input int d, input logic [3:0] a, input logic [3:0] b,
                            input logic [2:0] op, input int k);
        req_valid[d] = 1'b1;
        req_a[d]     = a;
        req_b[d]     = b;
        req_cin[d]   = 1'b0;
        req_op[d]    = op;
        res_ready[d] = 1'b0;
        for (int n = 0; n < k; n++) begin
            @(negedge clk);
            req_valid[d] = 1'b0;
        end
        rst[d] = 1'b1;
        @(negedge clk);
        rst[d] = 1'b0;
        // Reset clears every register, the completion counter included.
        model_reset(d);
        chk_idle_after_reset(d, $sformatf("abort%0d", k));
        for (int n = 0; n < lat_of(d) + 4; n++) begin
            @(negedge clk);
            check($sformatf("d%0d abort res_valid stays low", d), 32'(res_valid[d]), 32'd0);
            check($sformatf("d%0d abort busy", d), 32'(busy[d]), 32'd0);
        end
    endtask

    // Hard time limit so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1);
    end

    // Main stimulus sequence.
    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; req_valid[i] = 1'b0; req_a[i] = 4'd0; req_b[i] = 4'd0;
            req_cin[i] = 1'b0; req_op[i] = 3'b000; res_ready[i] = 1'b0;
`ifdef ULA_SEQ_ACC_EN
            req_acc[i] = 1'b0;
`endif
            model_reset(i);
        end
        @(negedge clk);
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        chk_idle_after_reset(0, "reset");
        chk_idle_after_reset(1, "reset");

        // 5 + 3 add, LAT=1: result 8 three cycles after accept.
        do_op(0, 4'd5, 4'd3, 1'b0, 3'b000, 1'b0, 0);
        // Consumer stalls ten cycles while new requests are presented.
        do_op(0, 4'd9, 4'd4, 1'b1, 3'b001, 1'b0, 10);
        // Illegal opcode: one-cycle answer with error, datapath untouched.
        do_op(0, 4'd7, 4'd7, 1'b1, 3'b111, 1'b0, 2);
        do_op(0, 4'd2, 4'd5, 1'b0, 3'b001, 1'b0, 0);
`ifdef ULA_SEQ_ACC_EN
        // 5 + 7 = 12 then reuse it as operand A: 12 - 2.
        do_op(0, 4'd5, 4'd7, 1'b0, 3'b000, 1'b0, 0);
        do_op(0, 4'd0, 4'd2, 1'b1, 3'b001, 1'b1, 1);
        check("d0 acc result", 32'(res_data[0]), 32'd10);
`endif

        // LAT=4 division by zero, then resets during WAIT and during DONE.
        do_op(1, 4'd7, 4'd0, 1'b0, 3'b110, 1'b0, 1);
        abort_op(1, 4'd9, 4'd3, 3'b100, 3);
        abort_op(1, 4'd9, 4'd3, 3'b000, LAT1 + 2);
        for (int i = 0; i < 20; i++) begin
            do_op(1, 4'($urandom), 4'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
                  $urandom_range(2, 0));
        end

        // Long random run on LAT=1 takes op_count through 255 -> 0.
        for (int i = 0; i < 300; i++) begin
            do_op(0, 4'($urandom), 4'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
                  $urandom_range(2, 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
